// File: rtl/serial_sub.sv
// -----------------------------------------------------------------------------
// serial_sub
//   Bit-serial N-bit subtractor. Captures a, b and bin on an accepted start.
//   Then it resolves a - b - bin one bit per clock, LSB first, through a single
//   full-subtractor cell and a borrow flip-flop.
//
// Ports
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset
//   start : operation request, sampled only while idle
//   a     : minuend (N bits), captured on the accepting edge
//   b     : subtrahend (N bits), captured on the accepting edge
//   bin   : initial borrow-in, captured on the accepting edge
//   busy  : high while bits are being resolved
//   done  : one-cycle pulse; diff/bor valid from this cycle on
//   diff  : registered result, a - b - bin modulo 2^N
//   bor   : registered final borrow-out (a < b + bin, unsigned)
// -----------------------------------------------------------------------------
module serial_sub #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         bor
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [N-1:0]     sa;
    logic [N-1:0]     sb;
    logic [N-1:0]     sr;
    logic             br;
    logic [CNT_W-1:0] cnt;

    logic             d_bit;
    logic             br_next;
    logic [N-1:0]     sr_next;

    // One-bit full-subtractor cell: difference and borrow-out.
    function automatic logic fs_diff(input logic x, input logic y, input logic bi);
        return x ^ y ^ bi;
    endfunction

    function automatic logic fs_borrow(input logic x, input logic y, input logic bi);
        return (~x & y) | (~(x ^ y) & bi);
    endfunction

    always_comb begin
        d_bit   = fs_diff(sa[0], sb[0], br);
        br_next = fs_borrow(sa[0], sb[0], br);
        // Result bits enter at the MSB so that after N shifts the LSB sits at bit 0.
        sr_next = {d_bit, sr[N-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            bor   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= bin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    sr  <= sr_next;
                    br  <= br_next;
                    cnt <= cnt + CNT_W'(1);
                    // Final bit: publish the completed word, including this edge's bit.
                    if (cnt == CNT_W'(N - 1)) begin
                        diff  <= sr_next;
                        bor   <= br_next;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_sub.sv
// -----------------------------------------------------------------------------
// tb_serial_sub
//   Directed and random self-checking bench for serial_sub at N=8, plus an
//   exhaustive sweep of a second instance at N=2.
// -----------------------------------------------------------------------------
module tb_serial_sub;

    logic       clk;
    logic       rst;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       bin8;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       bor8;

    logic       start2;
    logic [1:0] a2;
    logic [1:0] b2;
    logic       bin2;
    logic       busy2;
    logic       done2;
    logic [1:0] diff2;
    logic       bor2;

    int checks;
    int errors;
    int done_cnt8;

    serial_sub #(.N(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .bin   (bin8),
        .busy  (busy8),
        .done  (done8),
        .diff  (diff8),
        .bor   (bor8)
    );

    serial_sub #(.N(2)) dut2 (
        .clk   (clk),
        .rst   (rst),
        .start (start2),
        .a     (a2),
        .b     (b2),
        .bin   (bin2),
        .busy  (busy2),
        .done  (done2),
        .diff  (diff2),
        .bor   (bor2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done8 === 1'b1) done_cnt8 <= done_cnt8 + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full N=8 transaction with cycle-by-cycle handshake checks.
    task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                       input logic [7:0] ediff, input logic ebor);
        int d0;
        a8 = ia; b8 = ib; bin8 = ibin; start8 = 1'b1;
        tick();                                   // E0
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        d0 = done_cnt8;
        for (int k = 0; k < 8; k++) begin
            chk("busy_run", {31'b0, busy8}, 32'd1);
            chk("done_run", {31'b0, done8}, 32'd0);
            tick();                               // E1..E8
        end
        chk("done_pulse", {31'b0, done8}, 32'd1);
        chk("busy_done",  {31'b0, busy8}, 32'd0);
        chk("diff",       {24'b0, diff8}, {24'b0, ediff});
        chk("bor",        {31'b0, bor8},  {31'b0, ebor});
        tick();                                   // back to IDLE
        chk("done_fall",  {31'b0, done8}, 32'd0);
        chk("done_once",  done_cnt8, d0 + 1);
        chk("diff_hold",  {24'b0, diff8}, {24'b0, ediff});
        chk("bor_hold",   {31'b0, bor8},  {31'b0, ebor});
    endtask

    task automatic op2(input logic [1:0] ia, input logic [1:0] ib, input logic ibin);
        logic [2:0] r;
        r = {1'b0, ia} - {1'b0, ib} - {2'b0, ibin};
        a2 = ia; b2 = ib; bin2 = ibin; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        a2 = ~ia; b2 = ~ib;
        chk("n2_busy1", {31'b0, busy2}, 32'd1);
        tick();
        chk("n2_busy2", {31'b0, busy2}, 32'd1);
        tick();
        chk("n2_done",  {31'b0, done2}, 32'd1);
        chk("n2_diff",  {30'b0, diff2}, {30'b0, r[1:0]});
        chk("n2_bor",   {31'b0, bor2},  {31'b0, r[2]});
        tick();
        chk("n2_idle",  {31'b0, done2}, 32'd0);
    endtask

    initial begin
        int d0;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbin;
        logic [8:0] rr;

        checks = 0; errors = 0; done_cnt8 = 0;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; bin2 = 1'b0;

        // Reset state
        #2;
        chk("rst_busy", {31'b0, busy8}, 32'd0);
        chk("rst_done", {31'b0, done8}, 32'd0);
        chk("rst_diff", {24'b0, diff8}, 32'd0);
        chk("rst_bor",  {31'b0, bor8},  32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Directed vectors
        op8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
        op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
        op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        // Reset in the middle of RUN aborts the op and clears outputs at once
        a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
        tick();                                   // E0
        start8 = 1'b0;
        tick(); tick(); tick();                   // E1..E3
        d0 = done_cnt8;
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'b0, busy8}, 32'd0);
        chk("abort_done", {31'b0, done8}, 32'd0);
        chk("abort_diff", {24'b0, diff8}, 32'd0);
        chk("abort_bor",  {31'b0, bor8},  32'd0);
        tick(); tick();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        chk("abort_no_done", done_cnt8, d0);
        chk("abort_idle", {31'b0, busy8}, 32'd0);
        op8(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);
        op8(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);

        // start pulses and operand changes while busy are ignored
        a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; start8 = 1'b1;
        tick();                                   // E0
        d0 = done_cnt8;
        for (int k = 0; k < 8; k++) begin
            start8 = (k % 2 == 0);
            a8 = 8'h11; b8 = 8'h22; bin8 = 1'b1;
            chk("ign_busy", {31'b0, busy8}, 32'd1);
            tick();
        end
        chk("ign_done", {31'b0, done8}, 32'd1);
        chk("ign_diff", {24'b0, diff8}, 32'h1E);
        chk("ign_bor",  {31'b0, bor8},  32'd0);
        start8 = 1'b1;                            // start during DONE is ignored too
        tick();
        start8 = 1'b0;
        chk("ign_no_accept", {31'b0, busy8}, 32'd0);
        for (int k = 0; k < 12; k++) tick();
        chk("ign_one_done", done_cnt8, d0 + 1);

        // start held high: back-to-back ops with one IDLE cycle between them
        a8 = 8'h03; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        tick();                                   // E0
        for (int k = 0; k < 8; k++) tick();
        chk("b2b_done", {31'b0, done8}, 32'd1);
        chk("b2b_diff", {24'b0, diff8}, 32'h02);
        tick();
        chk("b2b_gap",  {31'b0, busy8 | done8}, 32'd0);
        tick();
        chk("b2b_reaccept", {31'b0, busy8}, 32'd1);
        start8 = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        chk("b2b_settle", {31'b0, busy8 | done8}, 32'd0);

        // Exhaustive N=2
        for (int ia = 0; ia < 4; ia++)
            for (int ib = 0; ib < 4; ib++)
                for (int ic = 0; ic < 2; ic++)
                    op2(2'(ia), 2'(ib), 1'(ic));

        // Random N=8 against the arithmetic reference
        for (int n = 0; n < 1000; n++) begin
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rbin = 1'($urandom_range(0, 1));
            rr   = {1'b0, ra} - {1'b0, rb} - {8'b0, rbin};
            op8(ra, rb, rbin, rr[7:0], rr[8]);
            if ((n % 7) == 3) begin
                tick(); tick();
                chk("rand_hold", {23'b0, bor8, diff8}, {23'b0, rr});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_sub.md
# serial_sub

Bit-serial N-bit subtractor that accepts two parallel operands and a borrow-in, then resolves the difference one bit per clock, LSB first. It uses a single full-subtractor cell and a borrow flip-flop. It sits in the arithmetic datapath as the multi-bit, area-minimal consumer of the one-bit full-subtractor cell, and presents a start/busy/done handshake to the controlling logic.

## Interface
- N, 8, operand and result width in bits; legal range 2..32.

- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  N  minuend; captured on the accepting edge.
- b  input  N  subtrahend; captured on the accepting edge.
- bin  input  1  initial borrow-in; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; diff and bor are valid from this cycle on.
- diff  output  N  registered result, a - b - bin modulo 2^N.
- bor  output  1  registered final borrow-out; 1 when a < b + bin (unsigned).

## Operation
- States: IDLE, RUN, DONE. State is held in an explicit register.
- IDLE:
  - When start = 1: load shift registers sa <= a and sb <= b.
  - Load borrow register br <= bin and bit counter cnt <= 0.
  - Go to RUN.
  - When start = 0: stay in IDLE.
- RUN, one bit per edge:
  - d = sa[0] ^ sb[0] ^ br.
  - Next borrow: br <= (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br).
  - Shift d into the MSB of an internal result register sr, shifting sr right.
  - Shift sa and sb right by one.
  - cnt <= cnt + 1.
  - On the edge where cnt = N-1 (the Nth bit): go to DONE.
  - On that same edge, diff <= the completed result (including the final d) and bor <= the final borrow.
- DONE:
  - done = 1 for exactly one cycle.
  - Go to IDLE on the next edge unconditionally.
- diff and bor change only on the edge entering DONE. They hold until the next completion or reset.
- start is ignored in RUN and DONE. The operands a, b and bin are don't-care outside the accepting edge.
- cnt is sized to count 0..N-1; there is no wrap beyond N-1.

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - busy = 0, done = 0, diff = 0, bor = 0.
  - sa, sb, sr, br and cnt are cleared.
- Call the accepting edge E0. busy is high in the N cycles following E0.
- Bits are processed on edges E1..EN. diff and bor update on edge EN, and done is high in the cycle after EN.
- Latency from E0 to done is N+1 edges. For N = 8 that is 9 edges.
- The earliest next accept is the edge after done falls, giving a throughput of one operation per N+2 cycles.
- busy and done are never high together.
- Reset asserted during RUN or DONE:
  - The operation is aborted and no done pulse is produced.
  - Outputs return to 0 immediately.
  - After rst deasserts, the first accept is on the first edge at which start = 1.
- start held high continuously: an accept occurs on every IDLE edge, so operations run back-to-back with one IDLE cycle between them.

## Test plan
- N=8, a=0x5A, b=0x3C, bin=0, start pulse: busy high 8 cycles, done at E0+9, diff=0x1E, bor=0.
- a=0x00, b=0x01, bin=0 gives diff=0xFF, bor=1. Then a=0xFF, b=0xFF, bin=1 gives diff=0xFF, bor=1. Then a=0x80, b=0x7F, bin=1 gives diff=0x00, bor=0.
- Start pulses and operand changes during RUN (a=0x11, b=0x22) are ignored. The first op completes unchanged and exactly one done pulse is produced.
- rst asserted mid-RUN (after E3): outputs go to 0 within the same cycle and no done pulse follows. A subsequent op (0x10 - 0x01, bin=0) completes with diff=0x0F, bor=0.
- Exhaustive check, N=2 and N=8 random (1000 ops): every (a, b, bin) result matches the reference model, with {bor, diff} = {a - b - bin} in N+1-bit two's complement. done fires exactly once per op, and diff/bor hold stable between ops.
